rf_wb_arbiter: RTL

- Shares the register file's single write port between three writeback sources: ALU, load unit (MEM) and multiply/divide unit (MD).
- Each source has a one-entry holding buffer. Occupied buffers are granted round-robin, one per cycle, into a registered write stage.
- The registered write stage drives the register file's write-enable, write-address and write-data inputs.
- Provides read-after-write hazard flags for the two register-file read addresses, so decode can stall.

---
 rtl/rf_wb_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU, load
// (MEM) and multiply/divide (MD) writeback sources. Each source owns a
// one-entry holding buffer; occupied buffers are granted round-robin into a
// registered write stage. Also produces read-after-write hazard flags for the
// two decode read ports and a sticky duplicate-destination error flag.
// Optional build macro: RF_WB_ARBITER_BYPASS_EN adds byp_a_data/byp_b_data,
// forwarding the active write stage instead of flagging a hazard for it.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              hazard_a,
    output logic              hazard_b,
`ifdef RF_WB_ARBITER_BYPASS_EN
    output logic [DATA_W-1:0] byp_a_data,
    output logic [DATA_W-1:0] byp_b_data,
`endif
    output logic              err_dup
);
    localparam int NSRC = 3;

    // Source index 0 = ALU, 1 = MEM, 2 = MD (also the round-robin scan order).
    logic [NSRC-1:0]   in_valid;
    logic [ADDR_W-1:0] in_addr [NSRC];
    logic [DATA_W-1:0] in_data [NSRC];

    assign in_valid   = {md_valid, mem_valid, alu_valid};
    assign in_addr[0] = alu_addr;
    assign in_addr[1] = mem_addr;
    assign in_addr[2] = md_addr;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign in_data[2] = md_data;

    logic [NSRC-1:0]   buf_vld_q,  buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q [NSRC];
    logic [ADDR_W-1:0] buf_addr_d [NSRC];
    logic [DATA_W-1:0] buf_data_q [NSRC];
    logic [DATA_W-1:0] buf_data_d [NSRC];
    logic [1:0]        ptr_q,      ptr_d;
    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_dup_q,  err_dup_d;
    // Holds ready low until the first edge after reset is released.
    logic              rdy_en_q,   rdy_en_d;

    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [NSRC-1:0]   gnt_oh;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC-1:0]   xfer;
    logic [NSRC-1:0]   keep;
    logic [NSRC-1:0]   dup_hit;
    logic [NSRC-1:0]   hit_a;
    logic [NSRC-1:0]   hit_b;

    // Round-robin pick: scan from the pointer backwards so the closest occupied slot wins.
    always_comb begin
        int         s;
        logic [1:0] sel;
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        s       = 0;
        sel     = 2'd0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            s = int'(ptr_q) + k;
            if (s >= NSRC) s = s - NSRC;
            sel = 2'(s);
            if (buf_vld_q[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [NSRC-1:0] peer_hit;

        assign gnt_oh[gi]    = gnt_vld & (gnt_idx == 2'(gi));
        assign src_ready[gi] = rdy_en_q & (~buf_vld_q[gi] | gnt_oh[gi]);
        assign xfer[gi]      = in_valid[gi] & src_ready[gi];
        // Writes to register 0 are accepted but never buffered.
        assign keep[gi]      = xfer[gi] & (in_addr[gi] != '0);
        assign hit_a[gi]     = buf_vld_q[gi] & (buf_addr_q[gi] == RA);
        assign hit_b[gi]     = buf_vld_q[gi] & (buf_addr_q[gi] == RB);

        // Another pending write (buffered or arriving at the same edge) to the same register.
        for (genvar gj = 0; gj < NSRC; gj++) begin : g_peer
            if (gj == gi) begin : g_self
                assign peer_hit[gj] = 1'b0;
            end else begin : g_other
                assign peer_hit[gj] = (buf_vld_q[gj] & (buf_addr_q[gj] == in_addr[gi]))
                                    | (keep[gj] & (in_addr[gj] == in_addr[gi]));
            end
        end

        assign dup_hit[gi] = keep[gi] & ((rf_we_q & (rf_waddr_q == in_addr[gi])) | (|peer_hit));
    end

    assign alu_ready = src_ready[0];
    assign mem_ready = src_ready[1];
    assign md_ready  = src_ready[2];

    // Next-state: buffer fill/drain, write stage load, pointer advance, sticky error.
    always_comb begin
        buf_vld_d = buf_vld_q;
        for (int i = 0; i < NSRC; i++) begin
            buf_addr_d[i] = buf_addr_q[i];
            buf_data_d[i] = buf_data_q[i];
            if (keep[i]) begin
                buf_vld_d[i]  = 1'b1;
                buf_addr_d[i] = in_addr[i];
                buf_data_d[i] = in_data[i];
            end else if (gnt_oh[i]) begin
                buf_vld_d[i] = 1'b0;
            end
        end
        rf_we_d    = gnt_vld;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        ptr_d      = ptr_q;
        if (gnt_vld) begin
            rf_waddr_d = buf_addr_q[gnt_idx];
            rf_wdata_d = buf_data_q[gnt_idx];
            ptr_d      = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
        err_dup_d = err_dup_q | (|dup_hit);
        rdy_en_d  = 1'b1;
    end

    // State registers; reset drops every buffered and in-flight write at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_vld_q  <= '0;
            for (int i = 0; i < NSRC; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
            ptr_q      <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_dup_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_dup_q  <= err_dup_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err_dup  = err_dup_q;

    logic ws_hit_a, ws_hit_b;
    assign ws_hit_a = rf_we_q & (rf_waddr_q == RA);
    assign ws_hit_b = rf_we_q & (rf_waddr_q == RB);

`ifdef RF_WB_ARBITER_BYPASS_EN
    // The write stage is forwarded, so only buffered entries stall decode.
    assign hazard_a   = (RA != '0) & (|hit_a);
    assign hazard_b   = (RB != '0) & (|hit_b);
    assign byp_a_data = ((RA != '0) & ws_hit_a) ? rf_wdata_q : '0;
    assign byp_b_data = ((RB != '0) & ws_hit_b) ? rf_wdata_q : '0;
`else
    assign hazard_a = (RA != '0) & ((|hit_a) | ws_hit_a);
    assign hazard_b = (RB != '0) & ((|hit_b) | ws_hit_b);
`endif

endmodule
